// File: rtl/spi_led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_led_pkg
// Purpose  : Shared definitions for the SPI-controlled LED PWM register block:
//            frame FSM encoding and command-byte field layout.
// Revision : 1.0 - initial release
// ============================================================================
package spi_led_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Command byte layout: {rw, addr[6:0]}
  localparam int BYTE_W     = 8;
  localparam int CMD_RW_BIT = 7;
  localparam int CMD_ADDR_W = 7;
  localparam int WR_ADDR_W  = 4;

  // A set rw bit marks a read frame
  function automatic logic cmd_is_read(input logic [BYTE_W-1:0] cmd);
    return cmd[CMD_RW_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_led_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_led_regs_if
// Purpose  : Four-wire SPI bus bundle (chip select, clock, MOSI, MISO).
// Revision : 1.0 - initial release
// ============================================================================
interface spi_led_regs_if;
  logic spi_cs;
  logic spi_sck;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_cs, output spi_sck, output spi_mosi, input spi_miso);
  modport slave  (input spi_cs, input spi_sck, input spi_mosi, output spi_miso);
endinterface
`default_nettype wire

// File: rtl/spi_led_regs_byte_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_byte_slave
// Purpose  : Mode-0 SPI byte shifter. Synchronises the SPI pins into clk,
//            detects sck/cs edges, assembles 8-bit RX bytes and shifts a TX
//            byte out on MISO, one bit per synchronised sck falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module spi_byte_slave
  import spi_led_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  spi_led_regs_if.slave     spi,
  input  logic              tx_en,
  input  logic              tx_load,
  input  logic [BYTE_W-1:0] tx_byte,
  output logic              cs_fall,
  output logic              cs_rise,
  output logic              byte_done,
  output logic [BYTE_W-1:0] rx_byte
);

  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] rx_shift_q, rx_shift_d;
  logic [BYTE_W-1:0] tx_shift_q, tx_shift_d;
  logic              miso_q, miso_d;

  logic sck_rise, sck_fall, cs_active;

  // Two-flop synchronisers plus one history flop for edge detection; cs idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      cs_meta_q   <= spi.spi_cs;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      sck_meta_q  <= spi.spi_sck;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      mosi_meta_q <= spi.spi_mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign sck_rise  = sck_sync_q & ~sck_prev_q;
  assign sck_fall  = ~sck_sync_q & sck_prev_q;
  assign cs_fall   = ~cs_sync_q & cs_prev_q;
  assign cs_rise   = cs_sync_q & ~cs_prev_q;
  assign cs_active = ~cs_sync_q;

  // The completed byte is offered in the same cycle its eighth bit is sampled
  assign rx_byte   = {rx_shift_q[BYTE_W-2:0], mosi_sync_q};
  assign byte_done = sck_rise & cs_active & (bit_cnt_q == 3'd7);

  // Next-state for bit counter, RX/TX shifters and the MISO output flop
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    miso_d     = miso_q;

    if (!cs_active) begin
      bit_cnt_d  = 3'd0;
      rx_shift_d = '0;
    end else if (sck_rise) begin
      bit_cnt_d  = bit_cnt_q + 3'd1;
      rx_shift_d = rx_byte;
    end

    if (tx_load) begin
      tx_shift_d = tx_byte;
    end else if (sck_fall && cs_active) begin
      tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
    end

    // MISO only carries data while a read payload is being shifted out
    if (!tx_en || !cs_active) begin
      miso_d = 1'b0;
    end else if (sck_fall) begin
      miso_d = tx_shift_q[BYTE_W-1];
    end
  end

  // Shifter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      miso_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      miso_q     <= miso_d;
    end
  end

  assign spi.spi_miso = miso_q;

endmodule
`default_nettype wire

// File: rtl/spi_led_regs.sv
`default_nettype none
// ============================================================================
// Module   : spi_led_regs
// Purpose  : SPI-programmable bank of LED brightness registers driving one
//            PWM output per channel. Frames are {rw, addr} plus DATA_W/8
//            data bytes, MSB first.
// Revision : 1.0 - initial release
// ============================================================================
module spi_led_regs
  import spi_led_pkg::*;
#(
  parameter int                NUM_CH  = 8,
  parameter int                DATA_W  = 8,
  parameter int                PRESC   = 1,
  parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b1}}
) (
  input  logic                 sclk,
  input  logic                 s_rst,
  spi_led_regs_if.slave        spi,
  output logic [NUM_CH-1:0]    led,
  output logic                 wr_strobe,
  output logic [WR_ADDR_W-1:0] wr_addr,
  output logic                 frame_err
);

  localparam int                NBYTES   = DATA_W / BYTE_W;
  localparam int                PRESC_W  = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [DATA_W-1:0] PWM_LAST = {{(DATA_W-1){1'b1}}, 1'b0};

  // Byte-level SPI interface
  logic              cs_fall, cs_rise, byte_done, tx_en, tx_load;
  logic [BYTE_W-1:0] rx_byte, tx_byte;

  spi_byte_slave u_byte (
    .clk       (sclk),
    .rst       (s_rst),
    .spi       (spi),
    .tx_en     (tx_en),
    .tx_load   (tx_load),
    .tx_byte   (tx_byte),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .byte_done (byte_done),
    .rx_byte   (rx_byte)
  );

  // Frame state
  state_e                 state_q;
  logic [BYTE_W-1:0]      cmd_q;
  logic [1:0]             byte_idx_q;
  logic [DATA_W-1:0]      data_q;
  logic [DATA_W-1:0]      rd_q;
  logic                   wr_strobe_q, frame_err_q;
  logic [WR_ADDR_W-1:0]   wr_addr_q;

  // Register bank and PWM
  logic [DATA_W-1:0]  regs_q [NUM_CH];
  logic [DATA_W-1:0]  regs_d [NUM_CH];
  logic [DATA_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;

  // Frame decode
  logic              is_read, addr_ok, last_byte, data_byte;
  logic              commit, bad_wr, abort;
  logic [DATA_W-1:0] word, rd_val, rd_shift;

  // Decode of the current byte event into commit / error / MISO load actions
  always_comb begin
    is_read   = cmd_is_read(cmd_q);
    addr_ok   = (cmd_q[CMD_ADDR_W-1:0] < CMD_ADDR_W'(NUM_CH));
    last_byte = (byte_idx_q == 2'(NBYTES - 1));
    data_byte = (state_q == ST_DATA) && byte_done;
    word      = DATA_W'({data_q, rx_byte});
    rd_shift  = rd_q << BYTE_W;

    // Snapshot source for reads; unmapped addresses read back as zero
    rd_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rx_byte[CMD_ADDR_W-1:0] == CMD_ADDR_W'(i)) begin
        rd_val = regs_q[i];
      end
    end

    commit = data_byte && last_byte && !is_read && addr_ok;
    bad_wr = data_byte && last_byte && !is_read && !addr_ok;
    abort  = cs_rise && ((state_q == ST_CMD) || (state_q == ST_DATA));

    tx_en   = (state_q == ST_DATA) && is_read;
    tx_load = 1'b0;
    tx_byte = '0;
    if ((state_q == ST_CMD) && byte_done && cmd_is_read(rx_byte)) begin
      tx_load = 1'b1;
      tx_byte = BYTE_W'(rd_val >> (DATA_W - BYTE_W));
    end else if (data_byte && !last_byte && is_read) begin
      tx_load = 1'b1;
      tx_byte = BYTE_W'(rd_shift >> (DATA_W - BYTE_W));
    end
  end

  // Frame sequencer with registered strobe / address / error outputs
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      byte_idx_q  <= 2'd0;
      data_q      <= '0;
      rd_q        <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wr_strobe_q <= commit;
      frame_err_q <= bad_wr | abort;
      if (commit) begin
        wr_addr_q <= cmd_q[WR_ADDR_W-1:0];
      end

      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q    <= ST_CMD;
            byte_idx_q <= 2'd0;
            data_q     <= '0;
          end
        end
        ST_CMD: begin
          if (cs_rise) begin
            state_q <= ST_IDLE;
          end else if (byte_done) begin
            cmd_q      <= rx_byte;
            byte_idx_q <= 2'd0;
            rd_q       <= rd_val;
            state_q    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (cs_rise) begin
            state_q <= ST_IDLE;
          end else if (byte_done) begin
            data_q <= word;
            rd_q   <= rd_shift;
            if (last_byte) begin
              state_q <= ST_DONE;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end
        end
        ST_DONE: begin
          // Trailing sck activity is ignored until the frame closes
          if (cs_rise) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Register bank next-state: only a committed in-range write changes a channel
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && (cmd_q[CMD_ADDR_W-1:0] == CMD_ADDR_W'(i))) begin
        regs_d[i] = word;
      end
    end
  end

  // Register bank storage
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        regs_q[i] <= RST_VAL;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // PWM timebase: prescaler then a 0..2^DATA_W-2 counter so full scale is always on
  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    presc_d   = presc_q + PRESC_W'(1);
    if (presc_q == PRESC_W'(PRESC - 1)) begin
      presc_d   = '0;
      pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + DATA_W'(1);
    end
  end

  // PWM timebase registers
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      pwm_cnt_q <= '0;
      presc_q   <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      presc_q   <= presc_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_led
    assign led[g] = (pwm_cnt_q < regs_q[g]);
  end

  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_led_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_led_regs
// Purpose  : Self-checking bench for spi_led_regs (8-bit and 16-bit builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_led_regs;

  localparam int HALF = 8;   // sclk cycles per sck half period

  logic clk = 1'b0;
  logic rst8 = 1'b1;
  logic rst16 = 1'b1;
  always #5 clk = ~clk;

  spi_led_regs_if bus8();
  spi_led_regs_if bus16();

  logic cs8 = 1'b1, sck8 = 1'b0, mosi8 = 1'b0;
  logic cs16 = 1'b1, sck16 = 1'b0, mosi16 = 1'b0;
  assign bus8.spi_cs    = cs8;
  assign bus8.spi_sck   = sck8;
  assign bus8.spi_mosi  = mosi8;
  assign bus16.spi_cs   = cs16;
  assign bus16.spi_sck  = sck16;
  assign bus16.spi_mosi = mosi16;

  logic [7:0] led8, led16;
  logic       ws8, fe8, ws16, fe16;
  logic [3:0] wa8, wa16;

  spi_led_regs #(.NUM_CH(8), .DATA_W(8), .PRESC(1), .RST_VAL(8'hFF)) dut8 (
    .sclk(clk), .s_rst(rst8), .spi(bus8),
    .led(led8), .wr_strobe(ws8), .wr_addr(wa8), .frame_err(fe8)
  );

  spi_led_regs #(.NUM_CH(8), .DATA_W(16), .PRESC(1), .RST_VAL(16'hFFFF)) dut16 (
    .sclk(clk), .s_rst(rst16), .spi(bus16),
    .led(led16), .wr_strobe(ws16), .wr_addr(wa16), .frame_err(fe16)
  );

  // Pulse counters
  int ws8_n = 0, fe8_n = 0, ws16_n = 0, fe16_n = 0;
  always @(negedge clk) begin
    if (ws8)  ws8_n  <= ws8_n + 1;
    if (fe8)  fe8_n  <= fe8_n + 1;
    if (ws16) ws16_n <= ws16_n + 1;
    if (fe16) fe16_n <= fe16_n + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic cs, input logic sck, input logic mosi);
    if (sel) begin
      cs16 = cs; sck16 = sck; mosi16 = mosi;
    end else begin
      cs8 = cs; sck8 = sck; mosi8 = mosi;
    end
  endtask

  // Mode-0 transfer of the top nbits of tx; MISO sampled at each sck rise
  task automatic xfer(input bit sel, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      drive(sel, 1'b0, 1'b0, tx[i]);
      repeat (HALF) @(negedge clk);
      drive(sel, 1'b0, 1'b1, tx[i]);
      rx[i] = sel ? bus16.spi_miso : bus8.spi_miso;
      repeat (HALF) @(negedge clk);
      drive(sel, 1'b0, 1'b0, tx[i]);
    end
  endtask

  // Complete frame of n bytes taken right-aligned from tx, first byte highest
  task automatic frame(input bit sel, input int n, input logic [23:0] tx, output logic [23:0] rx);
    logic [7:0] b;
    logic [7:0] r;
    rx = '0;
    drive(sel, 1'b0, 1'b0, 1'b0);
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      b = tx[8*(n-1-k) +: 8];
      xfer(sel, b, 8, r);
      rx = {rx[15:0], r};
    end
    repeat (HALF) @(negedge clk);
    drive(sel, 1'b1, 1'b0, 1'b0);
    repeat (4*HALF) @(negedge clk);
  endtask

  task automatic count_led(input int idx, input int ncyc, output int cnt);
    cnt = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      if (led8[idx]) cnt++;
    end
  endtask

  typedef struct {
    logic [23:0] tx;
    logic        is_rd;
    logic [7:0]  exp_rd;
    int          exp_ws;
    int          exp_fe;
    logic [3:0]  exp_wa;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  initial begin
    logic [23:0] rx;
    logic [7:0]  r;
    int          ws0, fe0, cnt;

    vecs[0]  = '{24'h008500, 1'b1, 8'hFF, 0, 0, 4'h0};  // read after reset
    vecs[1]  = '{24'h000340, 1'b0, 8'h00, 1, 0, 4'h3};  // write ch3
    vecs[2]  = '{24'h008300, 1'b1, 8'h40, 0, 0, 4'h3};
    vecs[3]  = '{24'h008500, 1'b1, 8'hFF, 0, 0, 4'h3};  // untouched channel
    vecs[4]  = '{24'h000A12, 1'b0, 8'h00, 0, 1, 4'h3};  // out-of-range write
    vecs[5]  = '{24'h008A00, 1'b1, 8'h00, 0, 0, 4'h3};  // out-of-range read
    vecs[6]  = '{24'h0007A5, 1'b0, 8'h00, 1, 0, 4'h7};  // top channel
    vecs[7]  = '{24'h008700, 1'b1, 8'hA5, 0, 0, 4'h7};
    vecs[8]  = '{24'h000000, 1'b0, 8'h00, 1, 0, 4'h0};  // ch0 = 0
    vecs[9]  = '{24'h008000, 1'b1, 8'h00, 0, 0, 4'h0};
    vecs[10] = '{24'h008300, 1'b1, 8'h40, 0, 0, 4'h0};

    // Reset state
    repeat (4) @(negedge clk);
    rst8 = 1'b0;
    rst16 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst miso", {31'd0, bus8.spi_miso}, 32'd0);
    check("rst wr_strobe", {31'd0, ws8}, 32'd0);
    check("rst wr_addr", {28'd0, wa8}, 32'd0);
    check("rst frame_err", {31'd0, fe8}, 32'd0);
    check("rst led8", {24'd0, led8}, 32'hFF);
    check("rst led16", {24'd0, led16}, 32'hFF);

    // Table-driven frames on the 8-bit build
    for (int v = 0; v < NVEC; v++) begin
      ws0 = ws8_n;
      fe0 = fe8_n;
      frame(1'b0, 2, vecs[v].tx, rx);
      if (vecs[v].is_rd) check($sformatf("v%0d miso", v), {24'd0, rx[7:0]}, {24'd0, vecs[v].exp_rd});
      check($sformatf("v%0d wr_strobe count", v), ws8_n - ws0, vecs[v].exp_ws);
      check($sformatf("v%0d frame_err count", v), fe8_n - fe0, vecs[v].exp_fe);
      check($sformatf("v%0d wr_addr", v), {28'd0, wa8}, {28'd0, vecs[v].exp_wa});
    end

    // PWM duty: ch3=0x40, ch7=0xA5, ch0=0x00
    count_led(3, 255, cnt);
    check("pwm ch3 one period", cnt, 64);
    count_led(3, 510, cnt);
    check("pwm ch3 two periods", cnt, 128);
    count_led(7, 255, cnt);
    check("pwm ch7 one period", cnt, 165);
    count_led(0, 510, cnt);
    check("pwm ch0 zero", cnt, 0);
    frame(1'b0, 2, 24'h0000FF, rx);
    count_led(0, 510, cnt);
    check("pwm ch0 full", cnt, 510);

    // Abort after 4 data bits
    ws0 = ws8_n;
    fe0 = fe8_n;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (HALF) @(negedge clk);
    xfer(1'b0, 8'h02, 8, r);
    xfer(1'b0, 8'h00, 4, r);
    repeat (HALF) @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4*HALF) @(negedge clk);
    check("abort wr_strobe count", ws8_n - ws0, 0);
    check("abort frame_err count", fe8_n - fe0, 1);
    frame(1'b0, 2, 24'h008200, rx);
    check("abort reg2 kept", {24'd0, rx[7:0]}, 32'hFF);
    ws0 = ws8_n;
    frame(1'b0, 2, 24'h000211, rx);
    check("post-abort write strobe", ws8_n - ws0, 1);
    frame(1'b0, 2, 24'h008200, rx);
    check("post-abort reg2", {24'd0, rx[7:0]}, 32'h11);

    // 16-bit build: write, read back, reset mid-frame
    ws0 = ws16_n;
    frame(1'b1, 3, 24'h011234, rx);
    check("w16 wr_strobe count", ws16_n - ws0, 1);
    check("w16 wr_addr", {28'd0, wa16}, 32'd1);
    frame(1'b1, 3, 24'h810000, rx);
    check("w16 readback", {16'd0, rx[15:0]}, 32'h1234);

    fe0 = fe16_n;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (HALF) @(negedge clk);
    xfer(1'b1, 8'h02, 8, r);
    xfer(1'b1, 8'h55, 8, r);
    rst16 = 1'b1;
    repeat (3) @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst16 = 1'b0;
    repeat (4*HALF) @(negedge clk);
    check("rst16 frame_err count", fe16_n - fe0, 0);
    check("rst16 wr_addr", {28'd0, wa16}, 32'd0);
    frame(1'b1, 3, 24'h810000, rx);
    check("rst16 reg1", {16'd0, rx[15:0]}, 32'hFFFF);
    frame(1'b1, 3, 24'h820000, rx);
    check("rst16 reg2", {16'd0, rx[15:0]}, 32'hFFFF);
    check("rst16 led", {24'd0, led16}, 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_led_regs.md
SPI_LED_REGS -- requirements
Module: spi_led_regs

Interface
REQ-001 Parameter NUM_CH, default 8, number of LED channels / registers (1..16).
REQ-002 Parameter DATA_W, default 8, register width in bits (8 or 16; multiple of 8).
REQ-003 Parameter PRESC, default 1, sclk cycles per PWM counter step (>=1).
REQ-004 Parameter RST_VAL, default all-ones, reset value of every channel register.
REQ-005 sclk  in  1  system clock; one clock domain; sclk >= 8x spi_sck.
REQ-006 s_rst  in  1  reset, asynchronous, active-high.
REQ-007 spi_cs  in  1  SPI chip select, active-low, asynchronous to sclk.
REQ-008 spi_sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous.
REQ-009 spi_mosi  in  1  SPI data in, MSB first.
REQ-010 spi_miso  out  1  SPI data out, MSB first; 0 while spi_cs high.
REQ-011 led  out  NUM_CH  per-channel PWM output, 1 = lit.
REQ-012 wr_strobe  out  1  one-cycle pulse on each committed register write.
REQ-013 wr_addr  out  4  address of the last committed write, held until the next.
REQ-014 frame_err  out  1  one-cycle pulse on an aborted or bad-address frame.

Function
REQ-015 spi_cs, spi_sck and spi_mosi each pass through a 2-flop synchronizer; sck rise/fall and cs fall/rise are edge-detected in sclk.
REQ-016 Frame = command byte {rw[7], addr[6:0]} followed by DATA_W/8 data bytes; rw=0 write, rw=1 read.
REQ-017 MOSI is sampled on the synchronized sck rising edge; MISO changes on the synchronized sck falling edge.
REQ-018 FSM states: IDLE, CMD, DATA, DONE; cs fall IDLE->CMD; 8th bit CMD->DATA; last data bit DATA->DONE; DONE->IDLE on cs rise.
REQ-019 Write with addr < NUM_CH: reg[addr] loads the assembled data word one sclk after the last data bit is sampled; wr_strobe pulses in the same cycle; wr_addr updates.
REQ-020 Write with addr >= NUM_CH: no register changes, no wr_strobe; frame_err pulses once at DONE.
REQ-021 Read: reg[addr] (or 0 if addr >= NUM_CH) is snapshotted at CMD->DATA; MSB is driven from the first falling edge after the command byte; registers are unchanged.
REQ-022 cs rise in CMD or DATA aborts the frame: no write, frame_err pulses once, FSM goes to IDLE.
REQ-023 Extra sck edges in DONE are ignored; MISO is 0 in DONE.
REQ-024 pwm_cnt is DATA_W bits wide, advances every PRESC sclk cycles, and counts 0..2^DATA_W-2 then wraps to 0.
REQ-025 led[i] = (pwm_cnt < reg[i]); value 0 gives always off, 2^DATA_W-1 gives always on.
REQ-026 A register write takes effect on led from the next sclk cycle; no PWM resync.

Reset
REQ-027 When s_rst asserts, all state clears immediately: FSM=IDLE, shift registers=0, pwm_cnt=0, prescaler=0, reg[i]=RST_VAL.
REQ-028 Output reset values: spi_miso=0, wr_strobe=0, wr_addr=0, frame_err=0, led=all-ones when RST_VAL is all-ones.
REQ-029 Reset mid-frame discards the frame without raising frame_err; the next cs fall starts a fresh frame.

Structure
REQ-030 A shared package spi_led_pkg holds the FSM state encoding, the rw bit position and the command-byte field widths.
REQ-031 The byte-level SPI shifter (synchronizers, edge detection, 8-bit RX/TX shift, byte-done pulse) is a sub-module named spi_byte_slave; framing, register bank and PWM live in spi_led_regs.

Verification
REQ-032 Write frame 0x03,0x40 (NUM_CH=8, DATA_W=8) -> reg[3]=0x40, one wr_strobe pulse, wr_addr=3, led[3] high for 64 of every 255 PWM steps.
REQ-033 Read frame 0x85,0x00 after reset -> MISO returns 0xFF, registers unchanged, no wr_strobe.
REQ-034 cs rises after 4 data bits of 0x02,0x00 -> reg[2] keeps its value, one frame_err pulse, and the next valid frame completes correctly.
REQ-035 Write 0x0A,0x12 with NUM_CH=8 -> no register changes, one frame_err pulse; read 0x8A -> MISO returns 0x00.
REQ-036 Writes of 0x00 and 0xFF to channel 0 -> led[0] constant 0, then constant 1 across two full PWM periods.
REQ-037 DATA_W=16: write 0x01,0x12,0x34 -> reg[1]=0x1234; read 0x81 -> MISO 0x1234; s_rst pulse mid-frame -> all regs RST_VAL, no frame_err.
